// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder
//
// Encodes RV32I instructions from field-level descriptors and writes each
// 32-bit word into instruction memory at a self-incrementing address. It is
// used by the boot/self-test path to load a program before the core runs.
//
// Handshake: a descriptor is consumed at a rising edge where in_valid and
// in_ready are both high. in_valid may be asserted at any time; in_ready is
// combinational (low while full or while start is high). Once consumed, a
// descriptor cannot be withdrawn. Legal descriptors produce exactly one
// imem_we pulse in the following cycle; illegal ones produce none and set err.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          restart load: clears pointer, count and err
//   in_valid       descriptor valid
//   in_ready       encoder can accept a descriptor
//   op_class       0 R, 1 I-alu, 2 load, 3 jalr, 4 store, 5 branch, 6 jal,
//                  7 lui, 8 auipc
//   funct3, alt    funct3 field; funct7[5] for R-type and shift-immediates
//   rd, rs1, rs2   register indices
//   imm            unencoded immediate / byte offset
//   imem_we        IMEM write strobe, one cycle per word
//   imem_addr      IMEM byte address
//   imem_wdata     encoded instruction
//   count          legal descriptors accepted since reset/start
//   full           count == 2**DEPTH_LOG2
//   err            sticky illegal-descriptor flag

module rv32i_inst_encoder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_class,
    input  logic [2:0]            funct3,
    input  logic                  alt,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  err
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   word;
    logic          illegal;
    logic          hs;

    // ------------------------------------------------------------------
    // Instruction encoder
    // ------------------------------------------------------------------
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op_class)
            4'd0: begin
                word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_R};
                // Only add/sub and srl/sra have an alternate form.
                if (alt && (funct3 != 3'b000) && (funct3 != 3'b101))
                    illegal = 1'b1;
            end
            4'd1: begin
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    word = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM};
                    if (alt && (funct3 == 3'b001))
                        illegal = 1'b1;
                end else begin
                    // alt has no meaning for the non-shift immediates.
                    word = {imm[11:0], rs1, funct3, rd, OP_IMM};
                end
            end
            4'd2: begin
                word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))
                    illegal = 1'b1;
            end
            4'd3: begin
                word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            4'd4: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                if (funct3[2] || (funct3[1:0] == 2'b11))
                    illegal = 1'b1;
            end
            4'd5: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                if ((funct3 == 3'b010) || (funct3 == 3'b011) || imm[0])
                    illegal = 1'b1;
            end
            4'd6: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                if (imm[0])
                    illegal = 1'b1;
            end
            4'd7: word = {imm[31:12], rd, OP_LUI};
            4'd8: word = {imm[31:12], rd, OP_AUIPC};
            default: illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and write pointer
    // ------------------------------------------------------------------
    assign full     = (count_q == CAP);
    assign in_ready = !full && !start;
    assign hs       = in_valid && in_ready;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            // hs is already blocked by in_ready while start is high.
            count_d = '0;
            err_d   = 1'b0;
            addr_d  = BASE_ADDR;
        end else if (hs) begin
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + 32'({count_q, 2'b00});
                wdata_d = word;
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder (DEPTH_LOG2=2, non-zero base address).
module tb_rv32i_inst_encoder;

  localparam int unsigned DL   = 2;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_class = 4'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        alt = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [DL:0] count;
  logic        full;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];

  rv32i_inst_encoder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .alt(alt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the expected queue.
  always @(negedge clk) begin
    if (rst_n && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                 imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e[63:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one descriptor for exactly one edge; expected write is queued
  // only for legal descriptors.
  task automatic drive(input logic [3:0] c, input logic [2:0] f, input logic a,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im, input bit legal,
                       input logic [31:0] ex_addr, input logic [31:0] ex_word);
    @(negedge clk);
    op_class = c; funct3 = f; alt = a; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    if (legal) exp_q.push_back({ex_addr, ex_word});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Illegal descriptor table
  logic [3:0]  ill_c  [6] = '{4'hF, 4'd5, 4'd4, 4'd0, 4'd1, 4'd6};
  logic [2:0]  ill_f  [6] = '{3'd0, 3'd0, 3'b011, 3'b001, 3'b001, 3'd0};
  logic        ill_a  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] ill_im [6] = '{32'd0, 32'd7, 32'd0, 32'd0, 32'd3, 32'd3};

  initial begin
    // ---------------- reset ----------------
    #12;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_full", 32'(full), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ---------------- back-to-back legal writes ----------------
    drive(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          1, BASE + 32'h0, 32'h002081B3);
    drive(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          1, BASE + 32'h4, 32'h402081B3);
    drive(4'd1, 3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3,          1, BASE + 32'h8, 32'h40335293);
    drive(4'd7, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000,   1, BASE + 32'hC, 32'h123453B7);
    idle();
    check("b2b_count", 32'(count), 32'd4);
    check("full_set", 32'(full), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_err", 32'(err), 32'd0);

    // A fifth descriptor stalls: no handshake, no write.
    drive(4'd0, 3'b000, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0, 0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("stall_we", 32'(imem_we), 32'd0);
    check("stall_count", 32'(count), 32'd4);

    // start: in_ready low during start, then high with pointer cleared.
    in_valid = 1'b0;
    start = 1'b1;
    #1;
    check("start_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_in_ready_high", 32'(in_ready), 32'd1);
    check("start_count", 32'(count), 32'd0);
    check("start_addr", imem_addr, BASE);

    // ---------------- control flow ----------------
    drive(4'd5, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,   1, BASE + 32'h0, 32'h00208463);
    drive(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1, BASE + 32'h4, 32'h001000EF);
    idle();
    check("cf_count", 32'(count), 32'd2);

    // ---------------- illegal descriptors ----------------
    for (int i = 0; i < 6; i++) begin
      drive(ill_c[i], ill_f[i], ill_a[i], 5'd1, 5'd1, 5'd2, ill_im[i], 0, 32'd0, 32'd0);
      idle();
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_count", 32'(count), 32'd2);
      check("illegal_we", 32'(imem_we), 32'd0);
      check("illegal_consumed_ready", 32'(in_ready), 32'd1);
      do_start();
      #1;
      check("start_err_clear", 32'(err), 32'd0);
      check("start_count_clear", 32'(count), 32'd0);
      drive(4'd5, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1, BASE, 32'h00208463);
      drive(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1, BASE + 32'h4, 32'h001000EF);
      idle();
    end

    // ---------------- more formats, fill to capacity ----------------
    do_start();
    drive(4'd4, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12,        1, BASE + 32'h0, 32'h0020A623);
    drive(4'd3, 3'b011, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         1, BASE + 32'h4, 32'h00008067);
    drive(4'd2, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC,  1, BASE + 32'h8, 32'hFFC12283);
    drive(4'd1, 3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,  1, BASE + 32'hC, 32'hFFF00093);
    idle();
    check("fill_count", 32'(count), 32'd4);
    check("fill_full", 32'(full), 32'd1);

    // ---------------- asynchronous reset during a write ----------------
    do_start();
    drive(4'hF, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0, 32'd0);
    drive(4'd8, 3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 32'h00001000, 1, BASE, 32'h00001517);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_we", 32'(imem_we), 32'd1);
    check("pre_rst_err", 32'(err), 32'd1);
    check("pre_rst_count", 32'(count), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(imem_we), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_addr", imem_addr, BASE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
